and_gate: RTL and testbench



---
 rtl/and_gate_if.sv | 24 ++
 rtl/and_gate.sv | 54 +++++
 tb/tb_and_gate.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/and_gate_if.sv
// Bus bundle for the and_gate block: operands and counter clear in, result,
// registered copy, rise flags and high-cycle count out.
interface and_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_cnt;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_rise;
  logic [CNT_W-1:0] hi_count;

  modport master (
    output a, b, clr_cnt,
    input  y, y_q, y_rise, hi_count
  );

  modport slave (
    input  a, b, clr_cnt,
    output y, y_q, y_rise, hi_count
  );
endinterface

// File: rtl/and_gate.sv
// Bitwise AND with a combinational result, a registered copy, per-bit rising
// edge pulses and a saturating count of cycles with every result bit high.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  and_gate_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] y_q_d, y_q_q;
  logic [WIDTH-1:0] y_rise_d, y_rise_q;
  logic [CNT_W-1:0] hi_count_d, hi_count_q;

  // The combinational result never touches clk or rst_n.
  assign and_w  = bus.a & bus.b;
  assign bus.y  = and_w;

  always_comb begin
    y_q_d      = and_w;
    y_rise_d   = and_w & ~y_q_q;
    hi_count_d = hi_count_q;
    if (bus.clr_cnt) begin
      hi_count_d = '0;
    end else if (&and_w) begin
      hi_count_d = sat_inc(hi_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_q      <= '0;
      y_rise_q   <= '0;
      hi_count_q <= '0;
    end else begin
      y_q_q      <= y_q_d;
      y_rise_q   <= y_rise_d;
      hi_count_q <= hi_count_d;
    end
  end

  assign bus.y_q      = y_q_q;
  assign bus.y_rise   = y_rise_q;
  assign bus.hi_count = hi_count_q;

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: a 1-bit/16-bit-counter instance and a
// 4-bit/4-bit-counter instance sharing clock and reset.
module tb_and_gate;

  logic clk;
  logic clk_en;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  and_gate_if #(.WIDTH(1), .CNT_W(16)) ifa ();
  and_gate_if #(.WIDTH(4), .CNT_W(4))  ifb ();

  and_gate #(.WIDTH(1), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  and_gate #(.WIDTH(4), .CNT_W(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    rst_n    = 1'b0;
    ifa.a = 1'b0; ifa.b = 1'b0; ifa.clr_cnt = 1'b0;
    ifb.a = 4'h0; ifb.b = 4'h0; ifb.clr_cnt = 1'b0;

    // Truth table with the clock idle and reset held
    #10;
    chk("rst_yq",     ifa.y_q, 1'b0);
    chk("rst_yrise",  ifa.y_rise, 1'b0);
    chk("rst_hi",     ifa.hi_count, 16'd0);
    #100;
    chk("tt_00", ifa.y, 1'b0);
    #10; ifa.b = 1'b1;
    #10; chk("tt_01", ifa.y, 1'b0);
    #10; ifa.a = 1'b1; ifa.b = 1'b0;
    #10; chk("tt_10", ifa.y, 1'b0);
    #10; ifa.b = 1'b1;
    #10; chk("tt_11", ifa.y, 1'b1);
    chk("tt_yq_in_rst", ifa.y_q, 1'b0);
    ifa.a = 1'b0; ifa.b = 1'b0;

    // Start clock and release reset away from the rising edge
    #3 clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_yq", ifa.y_q, 1'b0);
    chk("rel_hi", ifa.hi_count, 16'd0);

    // Registered path: inputs applied mid-cycle
    @(negedge clk);
    ifa.a = 1'b1; ifa.b = 1'b1;
    #1;
    chk("reg_y_now", ifa.y, 1'b1);
    chk("reg_yq_before", ifa.y_q, 1'b0);
    tick();
    chk("reg_yq", ifa.y_q, 1'b1);
    chk("reg_rise", ifa.y_rise, 1'b1);
    chk("reg_hi1", ifa.hi_count, 16'd1);
    tick();
    chk("reg_rise_once", ifa.y_rise, 1'b0);
    chk("reg_yq_held", ifa.y_q, 1'b1);

    // Counter: five high edges in total, then hold
    tick(); tick(); tick();
    chk("cnt_5", ifa.hi_count, 16'd5);
    @(negedge clk);
    ifa.b = 1'b0;
    tick();
    chk("cnt_hold1", ifa.hi_count, 16'd5);
    chk("cnt_yq0", ifa.y_q, 1'b0);
    tick();
    chk("cnt_hold2", ifa.hi_count, 16'd5);

    // Clear beats an all-high input in the same cycle
    @(negedge clk);
    ifa.b = 1'b1; ifa.clr_cnt = 1'b1;
    tick();
    chk("clr_hi", ifa.hi_count, 16'd0);
    chk("clr_rise", ifa.y_rise, 1'b1);
    @(negedge clk);
    ifa.clr_cnt = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_hi", ifa.hi_count, 16'd3);
    chk("pre_rst_yq", ifa.y_q, 1'b1);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_yq", ifa.y_q, 1'b0);
    chk("arst_rise", ifa.y_rise, 1'b0);
    chk("arst_hi", ifa.hi_count, 16'd0);
    chk("arst_y", ifa.y, 1'b1);
    tick();
    chk("arst_hold_yq", ifa.y_q, 1'b0);
    chk("arst_hold_hi", ifa.hi_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel2_yq", ifa.y_q, 1'b1);
    chk("rel2_rise", ifa.y_rise, 1'b1);
    chk("rel2_hi", ifa.hi_count, 16'd1);

    // WIDTH=4: partial overlap never counts
    @(negedge clk);
    ifb.a = 4'b1100; ifb.b = 4'b1010;
    #1;
    chk("w4_y", ifb.y, 4'b1000);
    tick();
    chk("w4_yq", ifb.y_q, 4'b1000);
    chk("w4_rise", ifb.y_rise, 4'b1000);
    chk("w4_hi0", ifb.hi_count, 4'd0);
    tick();
    chk("w4_hi0b", ifb.hi_count, 4'd0);

    // All-ones: increments per edge and saturates at 15
    @(negedge clk);
    ifb.a = 4'b1111; ifb.b = 4'b1111;
    tick();
    chk("w4_rise_new", ifb.y_rise, 4'b0111);
    chk("w4_hi1", ifb.hi_count, 4'd1);
    for (int i = 2; i <= 20; i++) begin
      tick();
      chk($sformatf("sat_%0d", i), ifb.hi_count, (i > 15) ? 32'd15 : 32'(i));
    end
    chk("sat_rise_low", ifb.y_rise, 4'b0000);

    @(negedge clk);
    ifb.clr_cnt = 1'b1;
    tick();
    chk("sat_clr", ifb.hi_count, 4'd0);
    @(negedge clk);
    ifb.clr_cnt = 1'b0;
    tick();
    chk("sat_restart", ifb.hi_count, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
